dot_seq: RTL
============

DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 Parameter DATA_W, 8, signed operand width; accumulator width is 2*DATA_W.
REQ-002 Parameter LEN_W, 4, width of the pair-count input.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle request; latches len; honoured only in IDLE.
REQ-007 len  in  LEN_W  number of operand pairs to accumulate (0..15).
REQ-008 in_valid  in  1  operand pair present.
REQ-009 in_ready  out  1  block accepts a pair; transfer occurs when in_valid && in_ready.
REQ-010 in_a, in_b  in  DATA_W each  signed operands.
REQ-011 res_valid  out  1  result held valid.
REQ-012 res_ready  in  1  consumer takes result; transfer occurs when res_valid && res_ready.
REQ-013 res  out  2*DATA_W  signed saturated dot product.
REQ-014 res_of, res_uf  out  1 each  sticky positive/negative saturation flags for this result.
REQ-015 busy  out  1  high in ACCUM and DONE.

Function
REQ-016 FSM has states IDLE, ACCUM and DONE.
REQ-017 IDLE: start with len>0 -> ACCUM; accumulator, flags and remaining count are cleared and the count loads len.
REQ-018 IDLE: start with len=0 -> DONE with res=0 and flags 0; res_valid rises on the next cycle.
REQ-019 ACCUM: in_ready=1; each transfer updates the accumulator on that edge and decrements the count; gaps in in_valid stall without side effects.
REQ-020 Transfer of the last pair -> DONE; res_valid is high in the cycle immediately after that edge.
REQ-021 Each accepted pair computes the sum = acc + in_a*in_b at full precision (2*DATA_W+1 bits minimum).
REQ-022 If the sum exceeds 32767, acc=32767 and res_of is set; if the sum is below -32768, acc=-32768 and res_uf is set; otherwise acc=sum.
REQ-023 Later pairs accumulate from the clamped value; flags stay set until the next accepted start.
REQ-024 DONE: in_ready=0; res, res_of and res_uf are held stable while res_valid=1 && res_ready=0.
REQ-025 DONE: a res_valid && res_ready transfer -> IDLE; start in the same cycle is ignored.
REQ-026 start outside IDLE is ignored; in_valid outside ACCUM is ignored.

Reset
REQ-027 rst forces IDLE from any state on the next edge, including mid-ACCUM and DONE.
REQ-028 After reset: in_ready=0, res_valid=0, busy=0, res=0, res_of=0, res_uf=0, count=0.

Structure
REQ-029 Package mac_pkg holds DATA_W, ACC_W, ACC_MAX (32767), ACC_MIN (-32768) and the state enum type.
REQ-030 Sub-module mac_sat contains the multiply, full-precision add, clamp and sticky-flag registers, with a clear input driven by the FSM.
REQ-031 dot_seq contains the FSM, the pair counter and the handshake logic only.

Verification
REQ-032 len=3, pairs (2,5), (-2,5), (-3,8) -> res=-24, of=0, uf=0; res_valid high one cycle after the third transfer.
REQ-033 len=3, pairs (126,126)x3 -> partials 15876 and 31752, then res=32767, of=1, uf=0.
REQ-034 len=3, pairs (-128,127)x3 -> partials -16256 and -32512, then res=-32768, uf=1, of=0.
REQ-035 len=4, pairs (126,126)x3 then (-1,1) -> res=32766, of=1 (sticky after recovery).
REQ-036 The bench covers two cases: len=0 -> res=0 valid next cycle; res_ready held low 5 cycles -> res stable, and a start during that window is ignored.
REQ-037 rst during the second pair of a len=3 run -> IDLE and all outputs at reset values; a fresh len=1 run with (-1,1) -> res=-1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the dot-product sequencer.
package mac_pkg;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 2 * DATA_W;
  localparam int ACC_MAX = 32767;
  localparam int ACC_MIN = -32768;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/dot_seq_if.sv
// Operand/result handshake bundle; master drives requests and operands, slave is the sequencer.
interface dot_seq_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) ();
  logic                       start;
  logic [LEN_W-1:0]           len;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   in_a;
  logic signed [DATA_W-1:0]   in_b;
  logic                       res_valid;
  logic                       res_ready;
  logic signed [2*DATA_W-1:0] res;
  logic                       res_of;
  logic                       res_uf;
  logic                       busy;

  modport master (
    output start, len, in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res, res_of, res_uf, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res, res_of, res_uf, busy
  );
endinterface

// File: rtl/mac_sat.sv
// Signed multiply-accumulate with clamp to the accumulator range and sticky saturation flags.
module mac_sat import mac_pkg::*; #(
  parameter int DATA_W = mac_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] acc,
  output logic                       of,
  output logic                       uf
);
  localparam int AW    = 2 * DATA_W;
  localparam int SUM_W = AW + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO = {2'b11, {(AW-1){1'b0}}};

  logic signed [AW-1:0]    prod;
  logic signed [SUM_W-1:0] sum;

  // One guard bit covers acc + product without wrapping.
  assign prod = a * b;
  assign sum  = SUM_W'(acc) + SUM_W'(prod);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      of  <= 1'b0;
      uf  <= 1'b0;
    end else if (en) begin
      if (sum > SAT_HI) begin
        acc <= SAT_HI[AW-1:0];
        of  <= 1'b1;
      end else if (sum < SAT_LO) begin
        acc <= SAT_LO[AW-1:0];
        uf  <= 1'b1;
      end else begin
        acc <= sum[AW-1:0];
      end
    end
  end
endmodule

// File: rtl/dot_seq.sv
// Dot-product sequencer: accepts len operand pairs, then holds the saturated sum until taken.
//   state   | meaning
//   S_IDLE  | waiting for start; latches len and clears the accumulator
//   S_ACCUM | accepting operand pairs until the count reaches zero
//   S_DONE  | result held valid until the consumer takes it
module dot_seq import mac_pkg::*; #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int LEN_W  = 4
) (
  input  logic     clk,
  input  logic     rst,
  dot_seq_if.slave bus
);
  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic             clr;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (xfer && cnt == LEN_W'(1)) state_nxt = S_DONE;
      S_DONE:  if (bus.res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_ACCUM);
    bus.res_valid = (state == S_DONE);
    bus.busy      = (state != S_IDLE);
    clr           = (state == S_IDLE) && bus.start;
    xfer          = bus.in_valid && (state == S_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= bus.len;
    else if (xfer) cnt <= cnt - LEN_W'(1);
  end

  mac_sat #(.DATA_W(DATA_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (xfer),
    .a   (bus.in_a),
    .b   (bus.in_b),
    .acc (bus.res),
    .of  (bus.res_of),
    .uf  (bus.res_uf)
  );
endmodule
